// File: rtl/omp_pkg.sv
// Shared types and width helpers for the offset-then-multiply pixel datapath.
package omp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } omp_state_t;

    function automatic int sum_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int out_w(input int dw);
        return 2 * dw + 2;
    endfunction

endpackage

// File: rtl/offset_mult_pipe_if.sv
// Operand/result handshake bundle: slave is the datapath, master drives operands and sinks results.
interface offset_mult_pipe_if
    import omp_pkg::*;
#(
    parameter int DATA_W = 4
);
    localparam int OUT_W = out_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  e;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, e
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, e
    );
endinterface

// File: rtl/omp_pipe_stage.sv
// Generic valid/data pipeline register; data only updates when a valid item is loaded.
module omp_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         ld_i,
    input  logic         vld_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] d_o
);
    logic         vld_q;
    logic [W-1:0] d_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q <= 1'b0;
            d_q   <= '0;
        end else if (ld_i) begin
            vld_q <= vld_i;
            if (vld_i) d_q <= d_i;
        end
    end

    assign vld_o = vld_q;
    assign d_o   = d_q;
endmodule

// File: rtl/offset_mult_pipe.sv
// Two-stage (a+OFFSET)*(b+OFFSET) datapath with start/stop/drain control.
// Optional result saturation at CLAMP_MAX when OMP_CLAMP_EN is defined.
module offset_mult_pipe
    import omp_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int OFFSET    = 3,
    parameter int CLAMP_MAX = 255
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start_i,
    input  logic                     stop_i,
    output logic                     busy_o,
    offset_mult_pipe_if.slave        bus
);
    localparam int SUM_W = sum_w(DATA_W);
    localparam int OUT_W = out_w(DATA_W);
    localparam logic [SUM_W-1:0] OFF     = SUM_W'(OFFSET);
    localparam logic [OUT_W-1:0] CLAMP_V = OUT_W'(CLAMP_MAX);
`ifdef OMP_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    omp_state_t         state_q;
    logic               v1, v2;
    logic               s2_load, s1_adv, in_xfer;
    logic [SUM_W-1:0]   sum_a_d, sum_b_d, s1_a, s1_b;
    logic [OUT_W-1:0]   prod, prod_d, e_q;

    // Backpressure ripples from the output: a stage may load once the one ahead can.
    assign s2_load      = !v2 || bus.out_ready;
    assign s1_adv       = !v1 || s2_load;
    assign bus.in_ready = (state_q == RUN) && s1_adv;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    assign sum_a_d = SUM_W'(bus.a) + OFF;
    assign sum_b_d = SUM_W'(bus.b) + OFF;

    omp_pipe_stage #(.W(2*SUM_W)) u_s1 (
        .clk   (clk),
        .n_rst (n_rst),
        .ld_i  (s1_adv),
        .vld_i (in_xfer),
        .d_i   ({sum_a_d, sum_b_d}),
        .vld_o (v1),
        .d_o   ({s1_a, s1_b})
    );

    assign prod   = OUT_W'(s1_a) * OUT_W'(s1_b);
    assign prod_d = (CLAMP_ON && (prod > CLAMP_V)) ? CLAMP_V : prod;

    omp_pipe_stage #(.W(OUT_W)) u_s2 (
        .clk   (clk),
        .n_rst (n_rst),
        .ld_i  (s2_load),
        .vld_i (v1),
        .d_i   (prod_d),
        .vld_o (v2),
        .d_o   (e_q)
    );

    assign bus.out_valid = v2;
    assign bus.e         = e_q;

    // stop takes priority over start; start is only honoured from IDLE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_q <= RUN;
                RUN:     if (stop_i) state_q <= DRAIN;
                DRAIN:   if (!v1 && !v2) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE) || v1 || v2;
endmodule

// File: tb/tb_offset_mult_pipe.sv
// Directed-vector bench for offset_mult_pipe (DATA_W=4, OFFSET=3, CLAMP_MAX=255).
module tb_offset_mult_pipe;
    logic clk = 1'b0;
    logic n_rst;
    logic start, stop, busy;
    int   nvec = 0;
    int   nerr = 0;

    offset_mult_pipe_if #(.DATA_W(4)) bus();

    offset_mult_pipe #(.DATA_W(4), .OFFSET(3), .CLAMP_MAX(255)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .start_i (start),
        .stop_i  (stop),
        .busy_o  (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_e",         32'(bus.e),         0);
        chk("rst_in_ready",  32'(bus.in_ready),  0);
        chk("rst_busy",      32'(busy),          0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        chk("idle_in_ready", 32'(bus.in_ready), 0);

        // 1: single item (2+3)*(5+3)=40
        go_run();
        chk("t1_busy_run",  32'(busy),         1);
        chk("t1_in_ready",  32'(bus.in_ready), 1);
        bus.a = 4'd2; bus.b = 4'd5; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t1_ov_s1",     32'(bus.out_valid), 0);
        chk("t1_busy_s1",   32'(busy),          1);
        tick();
        chk("t1_ov",        32'(bus.out_valid), 1);
        chk("t1_e",         32'(bus.e),         40);
        tick();
        chk("t1_ov_done",   32'(bus.out_valid), 0);
        chk("t1_busy_end",  32'(busy),          1);

        // 2: stream a=0..15, b=15 -> (a+3)*18
        bus.b = 4'd15;
        for (int i = 0; i <= 16; i++) begin
            bus.in_valid = (i < 16);
            bus.a = 4'(i);
            if (i < 16) chk($sformatf("t2_in_ready_%0d", i), 32'(bus.in_ready), 1);
            tick();
            if (i >= 1) begin
                chk($sformatf("t2_ov_%0d", i-1), 32'(bus.out_valid), 1);
                chk($sformatf("t2_e_%0d", i-1),  32'(bus.e), 32'((i - 1 + 3) * 18));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t2_ov_done", 32'(bus.out_valid), 0);

        // 3: backpressure, items 16, 25, 36
        bus.out_ready = 1'b0;
        bus.a = 4'd1; bus.b = 4'd1; bus.in_valid = 1'b1;
        chk("t3_ir_0", 32'(bus.in_ready), 1);
        tick();
        bus.a = 4'd2; bus.b = 4'd2;
        chk("t3_ir_1", 32'(bus.in_ready), 1);
        tick();
        bus.a = 4'd3; bus.b = 4'd3;
        chk("t3_ir_full", 32'(bus.in_ready), 0);
        tick();
        chk("t3_ir_full2", 32'(bus.in_ready), 0);
        chk("t3_hold_ov",  32'(bus.out_valid), 1);
        chk("t3_hold_e",   32'(bus.e), 16);
        bus.out_ready = 1'b1;
        #1;
        chk("t3_ir_rel",   32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("t3_e_1",      32'(bus.e), 25);
        tick();
        chk("t3_e_2",      32'(bus.e), 36);
        chk("t3_ov_2",     32'(bus.out_valid), 1);
        tick();
        chk("t3_ov_done",  32'(bus.out_valid), 0);

        // 4: stop with an accepted input, (4+3)*(6+3)=63, drain with a held output
        bus.a = 4'd4; bus.b = 4'd6; bus.in_valid = 1'b1; stop = 1'b1;
        chk("t4_ir", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0; stop = 1'b0;
        chk("t4_ir_drain", 32'(bus.in_ready), 0);
        chk("t4_busy",     32'(busy), 1);
        bus.out_ready = 1'b0;
        start = 1'b1;
        tick();
        chk("t4_ov",       32'(bus.out_valid), 1);
        chk("t4_e",        32'(bus.e), 63);
        tick();
        tick();
        chk("t4_hold_ov",  32'(bus.out_valid), 1);
        chk("t4_hold_e",   32'(bus.e), 63);
        chk("t4_hold_busy", 32'(busy), 1);
        chk("t4_start_ign", 32'(bus.in_ready), 0);
        start = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("t4_ov_clr",   32'(bus.out_valid), 0);
        chk("t4_busy_drn", 32'(busy), 1);
        tick();
        chk("t4_busy_idle", 32'(busy), 0);
        chk("t4_ir_idle",   32'(bus.in_ready), 0);

        // 5: asynchronous reset with two items in flight
        go_run();
        bus.out_ready = 1'b0;
        bus.a = 4'd1; bus.b = 4'd1; bus.in_valid = 1'b1;
        tick();
        bus.a = 4'd2; bus.b = 4'd2;
        tick();
        bus.in_valid = 1'b0;
        chk("t5_pre_ov", 32'(bus.out_valid), 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("t5_rst_ov",   32'(bus.out_valid), 0);
        chk("t5_rst_e",    32'(bus.e), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ir",   32'(bus.in_ready), 0);
        tick();
        n_rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("t5_no_stale", 32'(bus.out_valid), 0);
        chk("t5_idle",     32'(busy), 0);

        // 6: largest operands, saturated when clamping is built in
        go_run();
        bus.a = 4'd15; bus.b = 4'd15; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t6_ov", 32'(bus.out_valid), 1);
`ifdef OMP_CLAMP_EN
        chk("t6_e", 32'(bus.e), 255);
`else
        chk("t6_e", 32'(bus.e), 324);
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
        chk("t6_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
